hazard_ctrl: RTL and testbench

Hazard and pipeline-sequencing controller for the 5-stage RISC-V pipeline. It produces every stall, flush and forward-select signal for the F/D, D/E (id_ex), E/M and M/W registers and the E-stage operand muxes. It also sequences data-memory wait states with a bounded timeout, and keeps stall and flush event counters for performance debug.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forward-select codes and the resultSrc value that marks a load.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage operand forward select for one source register; M beats W.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rsE_i,
    input  logic [4:0] rdM_i,
    input  logic       regWriteM_i,
    input  logic [4:0] rdW_i,
    input  logic       regWriteW_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (rsE_i != 5'd0 && rsE_i == rdM_i && regWriteM_i) begin
            fwd_o = FWD_M;
        end else if (rsE_i != 5'd0 && rsE_i == rdW_i && regWriteW_i) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, with bounded
// data-memory wait sequencing and saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [1:0]       resultSrcE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             pcSrcE,
    input  logic             memReqM,
    input  logic             memAckM,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   waitCnt_q, waitCnt_d;
    logic              memErr_q, memErr_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

    logic [1:0] fwdA, fwdB;
    logic       lwStall, memBusy;
    logic       freeze;

    fwd_sel u_fwd_a (
        .rsE_i       (rs1E),
        .rdM_i       (rdM),
        .regWriteM_i (regWriteM),
        .rdW_i       (rdW),
        .regWriteW_i (regWriteW),
        .fwd_o       (fwdA)
    );

    fwd_sel u_fwd_b (
        .rsE_i       (rs2E),
        .rdM_i       (rdM),
        .regWriteM_i (regWriteM),
        .rdW_i       (rdW),
        .regWriteW_i (regWriteW),
        .fwd_o       (fwdB)
    );

    assign lwStall = (resultSrcE == RESULT_LOAD) && (rdE != 5'd0) &&
                     ((rdE == rs1D) || (rdE == rs2D));
    assign memBusy = memReqM && !memAckM;

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        memErr_d  = memErr_q;
        freeze    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (memBusy) begin
                    freeze    = 1'b1;
                    state_d   = ST_MEMWAIT;
                    waitCnt_d = WC_W'(1);
                end else if (pcSrcE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (lwStall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                // Branch/load-use hazards are not acted on while the pipe is frozen.
                if (memBusy) begin
                    freeze = 1'b1;
                    if (waitCnt_q == WC_W'(TIMEOUT - 1)) begin
                        state_d   = ST_FAULT;
                        waitCnt_d = '0;
                        memErr_d  = 1'b1;
                    end else begin
                        waitCnt_d = waitCnt_q + WC_W'(1);
                    end
                end else begin
                    state_d   = ST_RUN;
                    waitCnt_d = '0;
                end
            end
            ST_FAULT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d   = ST_RUN;
                waitCnt_d = '0;
            end
        endcase

        if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
        end

        // Everything combinational reads as idle while reset is held.
        if (!reset) begin
            stallF = 1'b0;
            stallD = 1'b0;
            flushD = 1'b0;
            flushE = 1'b0;
        end
    end

    assign stallE    = freeze && reset;
    assign stallM    = freeze && reset;
    assign flushW    = freeze && reset;
    assign forwardAE = reset ? fwdA : FWD_RF;
    assign forwardBE = reset ? fwdB : FWD_RF;

    assign stallCnt_d = (stallF && stallCnt_q != '1) ? stallCnt_q + CNT_W'(1) : stallCnt_q;
    assign flushCnt_d = ((flushD || flushE) && flushCnt_q != '1) ?
                        flushCnt_q + CNT_W'(1) : flushCnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            waitCnt_q  <= '0;
            memErr_q   <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            memErr_q   <= memErr_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign memErr   = memErr_q;
    assign stallCnt = stallCnt_q;
    assign flushCnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int MAXC    = (1 << CNT_W) - 1;

    typedef struct {
        bit       reset;
        bit [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        bit [1:0] resultSrcE;
        bit       regWriteM, regWriteW, pcSrcE, memReqM, memAckM;
    } stim_t;

    typedef struct {
        int fa, fb, stalls, flushes;
        bit known;
        int err, sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] resultSrcE;
    logic regWriteM, regWriteW, pcSrcE, memReqM, memAckM;
    logic [1:0] forwardAE, forwardBE;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
    logic [CNT_W-1:0] stallCnt, flushCnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .resultSrcE(resultSrcE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .rdM(rdM), .rdW(rdW), .pcSrcE(pcSrcE), .memReqM(memReqM), .memAckM(memAckM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .memErr(memErr), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model state: a count of consecutive busy cycles and a fault flag.
    bit mKnown = 0, mFault = 0;
    int mWait = 0, mErr = 0, mSc = 0, mFc = 0;

    function automatic int fwd_ref(int rs, int rdm, bit wm, int rdw, bit ww);
        if (rs != 0 && rs == rdm && wm) return 2;
        if (rs != 0 && rs == rdw && ww) return 1;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.reset = 1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit busy, lw, sF, fDE;
        reset = s.reset; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        rdE = s.rdE; rdM = s.rdM; rdW = s.rdW; resultSrcE = s.resultSrcE;
        regWriteM = s.regWriteM; regWriteW = s.regWriteW; pcSrcE = s.pcSrcE;
        memReqM = s.memReqM; memAckM = s.memAckM;

        busy = s.memReqM && !s.memAckM;
        lw   = s.resultSrcE == 2'b01 && s.rdE != 0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
        e = '{fa: 0, fb: 0, stalls: 0, flushes: 0, known: mKnown, err: mErr, sc: mSc, fc: mFc};
        if (s.reset) begin
            e.fa = fwd_ref(s.rs1E, s.rdM, s.regWriteM, s.rdW, s.regWriteW);
            e.fb = fwd_ref(s.rs2E, s.rdM, s.regWriteM, s.rdW, s.regWriteW);
            if (mFault || busy) begin
                e.stalls = 4'b1111; e.flushes = 3'b001;
            end else if (mWait == 0 && s.pcSrcE) begin
                e.flushes = 3'b110;
            end else if (mWait == 0 && lw) begin
                e.stalls = 4'b1100; e.flushes = 3'b010;
            end
        end
        exp_q.push_back(e);

        sF  = e.stalls[3];
        fDE = e.flushes[2] || e.flushes[1];
        if (!s.reset) begin
            mKnown = 1; mFault = 0; mWait = 0; mErr = 0; mSc = 0; mFc = 0;
        end else begin
            if (sF && mSc != MAXC) mSc++;
            if (fDE && mFc != MAXC) mFc++;
            if (!mFault) begin
                if (busy) begin
                    mWait++;
                    if (mWait == TIMEOUT) begin
                        mFault = 1; mErr = 1; mWait = 0;
                    end
                end else begin
                    mWait = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; score it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("forwardAE", int'(forwardAE), e.fa);
                chk("forwardBE", int'(forwardBE), e.fb);
                chk("stallFDEM", int'({stallF, stallD, stallE, stallM}), e.stalls);
                chk("flushDEW", int'({flushD, flushE, flushW}), e.flushes);
                if (e.known) begin
                    chk("memErr", int'(memErr), e.err);
                    chk("stallCnt", int'(stallCnt), e.sc);
                    chk("flushCnt", int'(flushCnt), e.fc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        reset = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        resultSrcE = 0; regWriteM = 0; regWriteW = 0; pcSrcE = 0; memReqM = 0; memAckM = 0;
        @(negedge clk);
        s = idle(); s.reset = 0; apply(s);

        // Forwarding priority and x0 exclusion.
        s = idle(); s.rs1E = 3; s.rdM = 3; s.regWriteM = 1; s.rdW = 3; s.regWriteW = 1; apply(s);
        s.rs1E = 0; apply(s);
        s = idle(); s.rs2E = 5; s.rdW = 5; s.regWriteW = 1; apply(s);
        // Load-use bubble, then idle.
        s = idle(); s.resultSrcE = 2'b01; s.rdE = 7; s.rs2D = 7; apply(s);
        apply(idle());
        // Branch wins over load-use.
        s.pcSrcE = 1; apply(s);
        apply(idle());
        // Three wait cycles then ack.
        s = idle(); s.memReqM = 1;
        repeat (3) apply(s);
        s.memAckM = 1; apply(s);
        apply(idle());
        // Same-cycle ack costs nothing.
        apply(s);
        // Timeout into FAULT, then one reset cycle.
        s.memAckM = 0;
        repeat (6) apply(s);
        apply(idle());
        s = idle(); s.reset = 0; apply(s);
        apply(idle());
        // Reset mid-wait.
        s = idle(); s.memReqM = 1;
        repeat (2) apply(s);
        s.reset = 0; apply(s);
        apply(idle());

        for (int i = 0; i < 3000; i++) begin
            s.reset      = ($urandom_range(0, 49) != 0);
            s.rs1D       = 5'($urandom_range(0, 3));
            s.rs2D       = 5'($urandom_range(0, 3));
            s.rs1E       = 5'($urandom_range(0, 3));
            s.rs2E       = 5'($urandom_range(0, 3));
            s.rdE        = 5'($urandom_range(0, 3));
            s.rdM        = 5'($urandom_range(0, 3));
            s.rdW        = 5'($urandom_range(0, 3));
            s.resultSrcE = 2'($urandom_range(0, 3));
            s.regWriteM  = 1'($urandom_range(0, 1));
            s.regWriteW  = 1'($urandom_range(0, 1));
            s.pcSrcE     = ($urandom_range(0, 5) == 0);
            s.memReqM    = ($urandom_range(0, 3) == 0);
            s.memAckM    = 1'($urandom_range(0, 1));
            apply(s);
        end

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
